// File: rtl/shifter_var_if.sv
// Bus bundle for shifter_var: shift control, serial input, tap select and tap/fill status.
// The master side drives enable/ES/delay_sel and observes SS/primed/fill_cnt.
interface shifter_var_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             enable;
    logic [WIDTH-1:0] ES;
    logic [SEL_W-1:0] delay_sel;
    logic [WIDTH-1:0] SS;
    logic             primed;
    logic [CNT_W-1:0] fill_cnt;

    modport master (
        output enable,
        output ES,
        output delay_sel,
        input  SS,
        input  primed,
        input  fill_cnt
    );

    modport slave (
        input  enable,
        input  ES,
        input  delay_sel,
        output SS,
        output primed,
        output fill_cnt
    );
endinterface

// File: rtl/shifter_var.sv
// Variable-tap shift register: DEPTH stages of WIDTH bits, output taken from a runtime-selected stage.
// Optional macro SHIFTER_FLUSH_EN adds a flush input that clears the pipeline like reset.
module shifter_var #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef SHIFTER_FLUSH_EN
    input  logic flush,
`endif
    shifter_var_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_reg  [DEPTH];
    logic [WIDTH-1:0] stage_next [DEPTH];
    logic [CNT_W-1:0] fill_cnt_reg;
    logic [CNT_W-1:0] fill_cnt_next;
    logic             clear_req;
    logic [SEL_W-1:0] eff_sel;

    // Reset and flush clear identically, so their relative priority is moot.
`ifdef SHIFTER_FLUSH_EN
    assign clear_req = reset | flush;
`else
    assign clear_req = reset;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = bus.enable ? bus.ES : stage_reg[gi];
            end else begin : g_body
                assign stage_next[gi] = bus.enable ? stage_reg[gi-1] : stage_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        fill_cnt_next = fill_cnt_reg;
        if (bus.enable && (fill_cnt_reg != FULL_CNT)) begin
            fill_cnt_next = fill_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
            fill_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= stage_next[i];
            end
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    // Selects beyond the last stage clamp to it; primed follows the select with no cycle of lag.
    assign eff_sel      = (bus.delay_sel > LAST_SEL) ? LAST_SEL : bus.delay_sel;
    assign bus.SS       = stage_reg[eff_sel];
    assign bus.fill_cnt = fill_cnt_reg;
    assign bus.primed   = (fill_cnt_reg > CNT_W'(eff_sel));
endmodule
